// File: rtl/trace_debugger_stimuli_player_if.sv
// rtl/trace_debugger_stimuli_player_if.sv - load, control and sample signals of the stimuli player
// The player itself sits on the slave modport; the bench or host driving it uses master.
interface trace_debugger_stimuli_player_if #(
   parameter int DEPTH = 64,
   parameter int GAP_W = 8
);
   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int DATA_W = 106 + GAP_W;

   logic              load_valid_i;
   logic              load_ready_o;
   logic [DATA_W-1:0] load_data_i;
   logic              clear_i;
   logic              start_i;
   logic              stop_i;
   logic              loop_i;
   logic              stall_i;
   logic              busy_o;
   logic              done_o;
   logic [CNT_W-1:0]  entries_o;
   logic [31:0]       sample_cnt_o;
   logic              ivalid_o;
   logic              iexception_o;
   logic              interrupt_o;
   logic [4:0]        cause_o;
   logic [31:0]       tval_o;
   logic [2:0]        priv_o;
   logic [31:0]       iaddr_o;
   logic [31:0]       instr_o;

   modport slave (
      input  load_valid_i, load_data_i, clear_i, start_i, stop_i, loop_i, stall_i,
      output load_ready_o, busy_o, done_o, entries_o, sample_cnt_o,
      output ivalid_o, iexception_o, interrupt_o, cause_o, tval_o, priv_o, iaddr_o, instr_o
   );

   modport master (
      output load_valid_i, load_data_i, clear_i, start_i, stop_i, loop_i, stall_i,
      input  load_ready_o, busy_o, done_o, entries_o, sample_cnt_o,
      input  ivalid_o, iexception_o, interrupt_o, cause_o, tval_o, priv_o, iaddr_o, instr_o
   );
endinterface

// File: rtl/trace_debugger_stimuli_player.sv
// rtl/trace_debugger_stimuli_player.sv - replays preloaded instruction samples with gaps, looping and stall
// Entries are loaded into a flop array in IDLE, then presented one per cycle with per-entry idle gaps.
module trace_debugger_stimuli_player #(
   parameter int DEPTH = 64,
   parameter int GAP_W = 8
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   trace_debugger_stimuli_player_if.slave         bus
);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int DATA_W = 106 + GAP_W;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
   localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

   typedef enum logic [1:0] {IDLE, PLAY, GAP, DONE} state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [CNT_W-1:0]  entries, entries_nxt;
   logic [CNT_W-1:0]  rd_ptr;
   logic [GAP_W-1:0]  gap_cnt, gap_nxt;
   logic [GAP_W-1:0]  cur_gap;
   logic [31:0]       sample_cnt;
   logic              valid_q, exc_q, intr_q;
   logic [4:0]        cause_q;
   logic [31:0]       tval_q, iaddr_q, instr_q;
   logic [2:0]        priv_q;

   logic              load_ready, load_fire;
   logic              present, blank, restart, advance;
   logic [PTR_W-1:0]  sel;
   logic [DATA_W-1:0] rd_word;

   assign load_ready = (state == IDLE) && (entries < CNT_MAX);
   assign load_fire  = bus.load_valid_i && load_ready;
   assign rd_word    = mem[sel];

   always_ff @(posedge clk_i) begin
      if (load_fire) mem[entries[PTR_W-1:0]] <= bus.load_data_i;
   end

   always_comb begin
      state_nxt   = state;
      entries_nxt = entries;
      gap_nxt     = gap_cnt;
      present     = 1'b0;
      blank       = 1'b0;
      restart     = 1'b0;
      advance     = 1'b0;
      sel         = '0;
      if (load_fire) entries_nxt = entries + CNT_ONE;
      if (bus.stop_i) begin
         state_nxt = IDLE;
         blank     = 1'b1;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.clear_i) begin
                  entries_nxt = '0;
                  state_nxt   = IDLE;
               end else if (bus.start_i && entries != '0) begin
                  // Start sees the entry count before any same-edge load.
                  state_nxt = PLAY;
                  present   = 1'b1;
                  restart   = 1'b1;
               end
            end
            PLAY: begin
               if (!bus.stall_i) begin
                  if (cur_gap != '0) begin
                     state_nxt = GAP;
                     gap_nxt   = cur_gap;
                     blank     = 1'b1;
                  end else begin
                     advance = 1'b1;
                  end
               end
            end
            GAP: begin
               if (!bus.stall_i) begin
                  if (gap_cnt == GAP_ONE) advance = 1'b1;
                  else                    gap_nxt = gap_cnt - GAP_ONE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
      if (advance) begin
         if (rd_ptr != entries) begin
            state_nxt = PLAY;
            present   = 1'b1;
            sel       = rd_ptr[PTR_W-1:0];
         end else if (bus.loop_i) begin
            state_nxt = PLAY;
            present   = 1'b1;
         end else begin
            state_nxt = DONE;
            blank     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= IDLE;
         entries    <= '0;
         rd_ptr     <= '0;
         gap_cnt    <= '0;
         cur_gap    <= '0;
         sample_cnt <= '0;
         valid_q    <= 1'b0;
         exc_q      <= 1'b0;
         intr_q     <= 1'b0;
         cause_q    <= '0;
         tval_q     <= '0;
         priv_q     <= '0;
         iaddr_q    <= '0;
         instr_q    <= '0;
      end else begin
         state   <= state_nxt;
         entries <= entries_nxt;
         gap_cnt <= gap_nxt;
         if (present) begin
            rd_ptr     <= {1'b0, sel} + CNT_ONE;
            sample_cnt <= restart ? 32'd1 : sample_cnt + 32'd1;
            cur_gap    <= rd_word[DATA_W-1:106];
            valid_q    <= 1'b1;
            exc_q      <= rd_word[105];
            intr_q     <= rd_word[104];
            cause_q    <= rd_word[103:99];
            tval_q     <= rd_word[98:67];
            priv_q     <= rd_word[66:64];
            iaddr_q    <= rd_word[63:32];
            instr_q    <= rd_word[31:0];
         end else if (blank) begin
            valid_q <= 1'b0;
            exc_q   <= 1'b0;
            intr_q  <= 1'b0;
            cause_q <= '0;
            tval_q  <= '0;
            priv_q  <= '0;
            iaddr_q <= '0;
            instr_q <= '0;
         end
      end
   end

   assign bus.load_ready_o = load_ready;
   assign bus.busy_o       = (state == PLAY) || (state == GAP);
   assign bus.done_o       = (state == DONE);
   assign bus.entries_o    = entries;
   assign bus.sample_cnt_o = sample_cnt;
   assign bus.ivalid_o     = valid_q;
   assign bus.iexception_o = exc_q;
   assign bus.interrupt_o  = intr_q;
   assign bus.cause_o      = cause_q;
   assign bus.tval_o       = tval_q;
   assign bus.priv_o       = priv_q;
   assign bus.iaddr_o      = iaddr_q;
   assign bus.instr_o      = instr_q;
endmodule

// File: tb/tb_trace_debugger_stimuli_player.sv
// tb/tb_trace_debugger_stimuli_player.sv - directed bench for the stimuli player
// Inputs change and outputs are sampled on the falling clock edge.
module tb_trace_debugger_stimuli_player;
   localparam int DEPTH = 64;
   localparam int GAP_W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   trace_debugger_stimuli_player_if #(.DEPTH(DEPTH), .GAP_W(GAP_W)) bus ();

   trace_debugger_stimuli_player #(.DEPTH(DEPTH), .GAP_W(GAP_W)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [113:0] mk(input logic [7:0] gap, input logic exc, input logic intr,
                                       input logic [4:0] cause, input logic [31:0] tval,
                                       input logic [2:0] priv, input logic [31:0] iaddr,
                                       input logic [31:0] instr);
      return {gap, exc, intr, cause, tval, priv, iaddr, instr};
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic load_entry(input logic [113:0] d);
      bus.load_valid_i = 1'b1;
      bus.load_data_i  = d;
      tick();
      bus.load_valid_i = 1'b0;
   endtask

   task automatic pulse_clear();
      bus.clear_i = 1'b1;
      tick();
      bus.clear_i = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
   endtask

   initial begin
      bus.load_valid_i = 1'b0;
      bus.load_data_i  = '0;
      bus.clear_i      = 1'b0;
      bus.start_i      = 1'b0;
      bus.stop_i       = 1'b0;
      bus.loop_i       = 1'b0;
      bus.stall_i      = 1'b0;
      tick();
      tick();
      check("rst_valid", bus.ivalid_o, 0);
      check("rst_ready", bus.load_ready_o, 1);
      check("rst_entries", bus.entries_o, 0);
      check("rst_busy", bus.busy_o, 0);
      check("rst_done", bus.done_o, 0);
      check("rst_cnt", bus.sample_cnt_o, 0);
      rst_n = 1'b1;
      tick();

      // Three back-to-back entries
      load_entry(mk(8'd0, 1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 32'h100, 32'hA0));
      load_entry(mk(8'd0, 1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 32'h104, 32'hA1));
      load_entry(mk(8'd0, 1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 32'h108, 32'hA2));
      check("t1_entries", bus.entries_o, 3);
      pulse_start();
      check("t1_v0", bus.ivalid_o, 1);
      check("t1_a0", bus.iaddr_o, 32'h100);
      check("t1_i0", bus.instr_o, 32'hA0);
      check("t1_busy", bus.busy_o, 1);
      tick();
      check("t1_v1", bus.ivalid_o, 1);
      check("t1_a1", bus.iaddr_o, 32'h104);
      tick();
      check("t1_v2", bus.ivalid_o, 1);
      check("t1_a2", bus.iaddr_o, 32'h108);
      check("t1_cnt2", bus.sample_cnt_o, 3);
      tick();
      check("t1_done", bus.done_o, 1);
      check("t1_vend", bus.ivalid_o, 0);
      check("t1_aend", bus.iaddr_o, 0);
      check("t1_cnt", bus.sample_cnt_o, 3);

      // Gap of two idle cycles after entry 0
      pulse_clear();
      check("t2_clr_entries", bus.entries_o, 0);
      check("t2_clr_done", bus.done_o, 0);
      load_entry(mk(8'd2, 1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 32'h100, 32'hB0));
      load_entry(mk(8'd0, 1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 32'h104, 32'hB1));
      pulse_start();
      check("t2_v0", bus.ivalid_o, 1);
      check("t2_a0", bus.iaddr_o, 32'h100);
      tick();
      check("t2_gap1", bus.ivalid_o, 0);
      check("t2_gap1_busy", bus.busy_o, 1);
      tick();
      check("t2_gap2", bus.ivalid_o, 0);
      tick();
      check("t2_v1", bus.ivalid_o, 1);
      check("t2_a1", bus.iaddr_o, 32'h104);
      check("t2_cnt", bus.sample_cnt_o, 2);
      tick();
      check("t2_done", bus.done_o, 1);

      // Looping over two entries, then stop
      pulse_clear();
      load_entry(mk(8'd0, 1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 32'h100, 32'hC0));
      load_entry(mk(8'd0, 1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 32'h104, 32'hC1));
      bus.loop_i = 1'b1;
      pulse_start();
      for (int i = 0; i < 7; i++) begin
         check($sformatf("t3_v%0d", i), bus.ivalid_o, 1);
         check($sformatf("t3_a%0d", i), bus.iaddr_o, (i % 2) ? 32'h104 : 32'h100);
         check($sformatf("t3_cnt%0d", i), bus.sample_cnt_o, i + 1);
         if (i < 6) tick();
      end
      bus.stop_i = 1'b1;
      tick();
      bus.stop_i = 1'b0;
      bus.loop_i = 1'b0;
      check("t3_stop_valid", bus.ivalid_o, 0);
      check("t3_stop_busy", bus.busy_o, 0);
      check("t3_stop_done", bus.done_o, 0);
      check("t3_stop_entries", bus.entries_o, 2);
      check("t3_stop_ready", bus.load_ready_o, 1);

      // Stall holds entry 1 for three cycles
      pulse_clear();
      load_entry(mk(8'd0, 1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 32'h100, 32'hD0));
      load_entry(mk(8'd0, 1'b0, 1'b1, 5'd5, 32'h55, 3'd3, 32'h104, 32'hDEADBEEF));
      load_entry(mk(8'd0, 1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 32'h108, 32'hD2));
      pulse_start();
      check("t4_a0", bus.iaddr_o, 32'h100);
      tick();
      check("t4_a1", bus.iaddr_o, 32'h104);
      bus.stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("t4_hold_v%0d", i), bus.ivalid_o, 1);
         check($sformatf("t4_hold_instr%0d", i), bus.instr_o, 32'hDEADBEEF);
         check($sformatf("t4_hold_cause%0d", i), bus.cause_o, 5);
         check($sformatf("t4_hold_intr%0d", i), bus.interrupt_o, 1);
         check($sformatf("t4_hold_priv%0d", i), bus.priv_o, 3);
         check($sformatf("t4_hold_tval%0d", i), bus.tval_o, 32'h55);
         check($sformatf("t4_hold_cnt%0d", i), bus.sample_cnt_o, 2);
      end
      bus.stall_i = 1'b0;
      tick();
      check("t4_a2", bus.iaddr_o, 32'h108);
      check("t4_cause2", bus.cause_o, 0);
      check("t4_cnt3", bus.sample_cnt_o, 3);
      tick();
      check("t4_done", bus.done_o, 1);
      check("t4_cnt_end", bus.sample_cnt_o, 3);

      // Fill to DEPTH, overflow write, empty start, same-edge load and start
      pulse_clear();
      for (int i = 0; i < DEPTH; i++) begin
         if (i == DEPTH - 1) check("t5_ready_last", bus.load_ready_o, 1);
         load_entry(mk(8'd0, 1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 32'(i), 32'(i)));
      end
      check("t5_full_ready", bus.load_ready_o, 0);
      check("t5_full_entries", bus.entries_o, DEPTH);
      load_entry(mk(8'd0, 1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 32'hFFFF, 32'hFFFF));
      check("t5_drop_entries", bus.entries_o, DEPTH);
      pulse_clear();
      check("t5_clr_entries", bus.entries_o, 0);
      pulse_start();
      check("t5_empty_valid", bus.ivalid_o, 0);
      check("t5_empty_busy", bus.busy_o, 0);
      check("t5_empty_done", bus.done_o, 0);
      bus.start_i = 1'b1;
      load_entry(mk(8'd0, 1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 32'h200, 32'hE0));
      bus.start_i = 1'b0;
      check("t5_sim_entries", bus.entries_o, 1);
      check("t5_sim_busy", bus.busy_o, 0);
      check("t5_sim_valid", bus.ivalid_o, 0);

      // Asynchronous reset in the middle of a gap
      pulse_clear();
      load_entry(mk(8'd5, 1'b1, 1'b0, 5'd2, 32'h0, 3'd1, 32'h100, 32'hF0));
      load_entry(mk(8'd0, 1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 32'h104, 32'hF1));
      pulse_start();
      check("t6_v0", bus.ivalid_o, 1);
      check("t6_exc0", bus.iexception_o, 1);
      tick();
      check("t6_gap_busy", bus.busy_o, 1);
      check("t6_gap_valid", bus.ivalid_o, 0);
      check("t6_gap_exc", bus.iexception_o, 0);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_busy", bus.busy_o, 0);
      check("t6_rst_cnt", bus.sample_cnt_o, 0);
      check("t6_rst_entries", bus.entries_o, 0);
      check("t6_rst_ready", bus.load_ready_o, 1);
      check("t6_rst_valid", bus.ivalid_o, 0);
      tick();
      rst_n = 1'b1;
      tick();
      check("t6_post_ready", bus.load_ready_o, 1);
      check("t6_post_entries", bus.entries_o, 0);
      check("t6_post_busy", bus.busy_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/trace_debugger_stimuli_player.md
Name: trace_debugger_stimuli_player

Overview:
- Replays a preloaded list of instruction samples onto the trace debugger's sample interface: valid, exception, interrupt, cause, tval, priv, iaddr, instr.
- It is the driving end of the interface that the stimuli capture monitor records.
- Samples are written into an internal flop array through a load port, then played back with per-entry idle gaps, optional looping and consumer stall.
- Used in simulation and FPGA benches to drive the trace debugger with deterministic traces.

Parameters:
- DEPTH, 64, number of sample entries stored (power of two, ≥2).
- GAP_W, 8, width of the per-entry idle-gap field.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- load_valid_i  in  1  load-port write request.
- load_ready_o  out  1  load port accepts an entry.
- load_data_i  in  106+GAP_W  entry to load. Bit fields (GAP_W=8):
  - [113:106] gap
  - [105] exception
  - [104] interrupt
  - [103:99] cause
  - [98:67] tval
  - [66:64] priv
  - [63:32] iaddr
  - [31:0] instr
- clear_i  in  1  empty the entry list (IDLE/DONE only).
- start_i  in  1  begin playback.
- stop_i  in  1  abort playback.
- loop_i  in  1  wrap to entry 0 after the last entry instead of finishing.
- stall_i  in  1  consumer stall; freeze all playback state and outputs.
- busy_o  out  1  state is PLAY or GAP.
- done_o  out  1  state is DONE.
- entries_o  out  $clog2(DEPTH)+1  number of loaded entries.
- sample_cnt_o  out  32  samples presented since last start (wraps mod 2^32).
- ivalid_o  out  1  sample valid.
- iexception_o  out  1  sample exception flag.
- interrupt_o  out  1  sample interrupt flag.
- cause_o  out  5  sample cause.
- tval_o  out  32  sample tval.
- priv_o  out  3  sample privilege level.
- iaddr_o  out  32  sample instruction address.
- instr_o  out  32  sample instruction word.

Behaviour:
- Reset values:
  - All outputs 0, except load_ready_o=1.
  - FSM IDLE; entries, rd_ptr, gap counter and sample_cnt all 0.
  - Array contents are not reset.
- FSM states: IDLE, PLAY, GAP, DONE. All sample outputs are registered.
- Load:
  - load_ready_o = (state==IDLE) && (entries<DEPTH).
  - A write occurs on a clock edge with load_valid_i && load_ready_o: entry stored at index `entries`, then entries increments.
  - When full, load_ready_o=0 and the write is dropped.
- clear_i in IDLE or DONE: entries←0 and state→IDLE. clear_i is ignored in PLAY/GAP.
- IDLE/DONE + start_i + entries>0 → PLAY.
  - At the same edge, entry 0 is registered onto the outputs with ivalid_o=1, rd_ptr←1 and sample_cnt←1.
  - First valid sample therefore appears one cycle after start_i.
  - start_i with entries==0 is ignored.
- PLAY: on each edge with stall_i=0, the current entry has been presented.
  - If its gap g>0: go to GAP, gap counter←g, ivalid_o←0.
  - If g=0: present the next entry directly, back-to-back.
- GAP:
  - Counter decrements each unstalled cycle.
  - ivalid_o stays 0 for exactly g cycles; then the next entry is presented (state→PLAY).
- Next entry after rd_ptr == entries (last entry consumed, including its gap):
  - loop_i=1: rd_ptr wraps to 0 and playback continues with no extra idle cycle.
  - loop_i=0: state→DONE and ivalid_o←0.
  - loop_i is sampled at the moment of wrap.
- Each newly presented entry increments sample_cnt.
- ivalid_o=0 → all sample field outputs are 0.
- stall_i=1 (PLAY/GAP): outputs, rd_ptr, gap counter and sample_cnt all hold, so a valid sample stays presented. Ignored in IDLE/DONE.
- Priority at an edge: stop_i > stall_i > advance.
  - stop_i in any state → IDLE, ivalid_o←0 next cycle; entries are kept.
  - stop_i and start_i together → stop wins.
- Simultaneous load_valid_i and start_i in IDLE: the load is accepted and start uses the pre-load entry count.
- rst_ni assertion mid-playback clears state immediately (asynchronous); outputs go to reset values without waiting for a clock.

Test Plan:
- Load 3 entries {iaddr=0x100,0x104,0x108; gap=0}, start_i pulse → ivalid_o=1 for exactly 3 consecutive cycles with iaddr 0x100,0x104,0x108, then done_o=1, ivalid_o=0, sample_cnt_o=3.
- Entry 0 gap=2, entry 1 gap=0 → pattern valid(0x100), 0, 0, valid(0x104), then DONE.
- Loop: 2 entries, loop_i=1, run 7 samples → iaddr 0x100,0x104,0x100,0x104,…; stop_i → IDLE next cycle, busy_o=0, entries_o=2.
- stall_i high 3 cycles during entry 1 (instr=0xDEADBEEF, cause=5, interrupt=1) → outputs hold unchanged for the 3 cycles, sequence resumes with no entry skipped, sample_cnt_o unaffected by the stall.
- Fill DEPTH entries → load_ready_o=0, extra write dropped, entries_o=DEPTH; start_i with entries==0 after clear_i → no ivalid_o, stays IDLE.
- Assert rst_ni=0 asynchronously mid-GAP → all outputs 0 immediately; load_ready_o=1 and entries_o=0 after release.
